// File: rtl/pin_responder_if.sv
// Scheduler command bus as seen by one pin responder: timed register writes,
// register reads, and the registered read-data return path.
interface pin_responder_if;
  logic [15:0] cmd_bus_addr;
  logic [31:0] cmd_bus_data;
  logic        cmd_bus_en;
  logic        cmd_bus_wr;
  logic        cmd_bus_rd;
  logic [31:0] rd_data;
  logic        rd_valid;

  modport master (
    output cmd_bus_addr, cmd_bus_data, cmd_bus_en, cmd_bus_wr, cmd_bus_rd,
    input  rd_data, rd_valid
  );

  modport slave (
    input  cmd_bus_addr, cmd_bus_data, cmd_bus_en, cmd_bus_wr, cmd_bus_rd,
    output rd_data, rd_valid
  );
endinterface

// File: rtl/pin_responder.sv
// Per-pin command-bus responder: hi-Z / constant / square-wave / record modes with a sample FIFO.
// Define RECORD_TIMESTAMP_EN to tag samples with current_time instead of a running sample index.
module pin_responder #(
  parameter logic [7:0] BASE_ADDR  = 8'h00,
  parameter int         FIFO_DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     current_time,
  pin_responder_if.slave  bus,
  input  logic            pin_in,
  output logic            pin_out,
  output logic            pin_oe,
  output logic            overflow
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [2:0] {IDLE, CONST, SQ_HI, SQ_LO, REC} state_t;

  function automatic logic [31:0] min1(input logic [31:0] v);
    return (v == 32'd0) ? 32'd1 : v;
  endfunction

  state_t      state_reg, state_next;
  logic [31:0] cnt_reg, cnt_next;
  logic [31:0] div_cnt_reg, div_cnt_next;
  logic [2:0]  mode_reg;
  logic [31:0] high_t_reg, low_t_reg, div_reg;

  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [8:0]    count_reg;
  logic          overflow_reg;
  logic [30:0]   sample_idx_reg;
  logic [31:0]   mem [FIFO_DEPTH];
  logic [31:0]   sample_q_reg;
  logic          sample_sel_reg;
  logic          rd_valid_reg;
  logic [31:0]   rd_word_reg;
  logic [31:0]   rd_mux;

  logic        hit, wr_hit, rd_hit, mode_wr, clr, pop, push, push_ok, full, enter_rec;
  logic [7:0]  reg_sel;
  logic [2:0]  mode_new;
  logic [31:0] entry;
  logic        unused_bits;

  // Write beats read when both qualifiers are high in the same cycle.
  assign hit       = bus.cmd_bus_en && (bus.cmd_bus_addr[15:8] == BASE_ADDR);
  assign wr_hit    = hit && bus.cmd_bus_wr;
  assign rd_hit    = hit && bus.cmd_bus_rd && !bus.cmd_bus_wr;
  assign reg_sel   = bus.cmd_bus_addr[7:0];
  assign mode_wr   = wr_hit && (reg_sel == 8'h00);
  assign clr       = wr_hit && (reg_sel == 8'h06);
  assign mode_new  = (bus.cmd_bus_data[2:0] > 3'd4) ? 3'd0 : bus.cmd_bus_data[2:0];
  assign enter_rec = mode_wr && (mode_new == 3'd4);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_reg   <= 3'd0;
      high_t_reg <= 32'd0;
      low_t_reg  <= 32'd0;
      div_reg    <= 32'd0;
    end else if (wr_hit) begin
      case (reg_sel)
        8'h00:   mode_reg   <= mode_new;
        8'h01:   high_t_reg <= bus.cmd_bus_data;
        8'h02:   low_t_reg  <= bus.cmd_bus_data;
        8'h03:   div_reg    <= bus.cmd_bus_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= 32'd0;
      div_cnt_reg <= 32'd0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      div_cnt_reg <= div_cnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    div_cnt_next = div_cnt_reg;
    push         = 1'b0;
    case (state_reg)
      SQ_HI: begin
        if (cnt_reg <= 32'd1) begin
          state_next = SQ_LO;
          cnt_next   = min1(low_t_reg);
        end else begin
          cnt_next = cnt_reg - 32'd1;
        end
      end
      SQ_LO: begin
        if (cnt_reg <= 32'd1) begin
          state_next = SQ_HI;
          cnt_next   = min1(high_t_reg);
        end else begin
          cnt_next = cnt_reg - 32'd1;
        end
      end
      REC: begin
        if (div_cnt_reg <= 32'd1) begin
          push         = 1'b1;
          div_cnt_next = min1(div_reg);
        end else begin
          div_cnt_next = div_cnt_reg - 32'd1;
        end
      end
      default: ;
    endcase
    // A MODE write always restarts the selected mode from a fresh count.
    if (mode_wr) begin
      case (mode_new)
        3'd1, 3'd2: state_next = CONST;
        3'd3: begin
          state_next = SQ_HI;
          cnt_next   = min1(high_t_reg);
        end
        3'd4: begin
          state_next   = REC;
          div_cnt_next = min1(div_reg);
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign pin_oe  = (state_reg == CONST) || (state_reg == SQ_HI) || (state_reg == SQ_LO);
  assign pin_out = (state_reg == SQ_HI) || ((state_reg == CONST) && (mode_reg == 3'd2));

`ifdef RECORD_TIMESTAMP_EN
  assign entry       = {current_time[30:0], pin_in};
  assign unused_bits = ^{current_time[31], sample_idx_reg};
`else
  assign entry       = {sample_idx_reg, pin_in};
  assign unused_bits = ^current_time;
`endif

  assign full    = (count_reg == 9'(FIFO_DEPTH));
  assign pop     = rd_hit && (reg_sel == 8'h04) && (count_reg != 9'd0);
  assign push_ok = push && (!full || pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= 9'd0;
      overflow_reg   <= 1'b0;
      sample_idx_reg <= 31'd0;
    end else begin
      if (clr) begin
        wr_ptr_reg   <= '0;
        rd_ptr_reg   <= '0;
        count_reg    <= 9'd0;
        overflow_reg <= 1'b0;
      end else begin
        if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
        if (pop)     rd_ptr_reg <= rd_ptr_reg + AW'(1);
        if (push_ok && !pop)      count_reg <= count_reg + 9'd1;
        else if (!push_ok && pop) count_reg <= count_reg - 9'd1;
        if (push && !push_ok) overflow_reg <= 1'b1;
      end
      if (clr || enter_rec) sample_idx_reg <= 31'd0;
      else if (push_ok)     sample_idx_reg <= sample_idx_reg + 31'd1;
    end
  end

  // Sample storage has no reset so it maps onto block RAM; the read port is registered.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= entry;
    sample_q_reg <= mem[rd_ptr_reg];
  end

  assign overflow = overflow_reg;

  always_comb begin
    rd_mux = 32'd0;
    case (reg_sel)
      8'h00:   rd_mux = {29'd0, mode_reg};
      8'h01:   rd_mux = high_t_reg;
      8'h02:   rd_mux = low_t_reg;
      8'h03:   rd_mux = div_reg;
      8'h05:   rd_mux = {16'd0, count_reg, overflow_reg, 3'd0, mode_reg};
      default: rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_reg   <= 1'b0;
      rd_word_reg    <= 32'd0;
      sample_sel_reg <= 1'b0;
    end else begin
      rd_valid_reg   <= rd_hit;
      rd_word_reg    <= rd_hit ? rd_mux : 32'd0;
      sample_sel_reg <= pop;
    end
  end

  assign bus.rd_valid = rd_valid_reg;
  assign bus.rd_data  = sample_sel_reg ? sample_q_reg : rd_word_reg;
endmodule

// File: tb/tb_pin_responder.sv
// Directed bench for pin_responder: register table, square wave, record FIFO, overflow/clear, reset.
module tb_pin_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] current_time = 32'd0;
  logic        pin_in = 1'b0;
  logic        pin_out, pin_oe, overflow;

  pin_responder_if bus();

  pin_responder #(.BASE_ADDR(8'h00), .FIFO_DEPTH(16)) dut (
    .clk(clk), .rst(rst), .current_time(current_time), .bus(bus),
    .pin_in(pin_in), .pin_out(pin_out), .pin_oe(pin_oe), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) current_time <= current_time + 32'd1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [31:0] data;
    logic        exp_valid;
    logic [31:0] exp_rd;
    logic        exp_oe;
    logic        exp_out;
  } vec_t;

  vec_t vecs[20];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
    bus.cmd_bus_addr = a;
    bus.cmd_bus_data = d;
    bus.cmd_bus_en   = 1'b1;
    bus.cmd_bus_wr   = 1'b1;
    tick();
    bus.cmd_bus_en   = 1'b0;
    bus.cmd_bus_wr   = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [15:0] a, input logic [31:0] exp);
    bus.cmd_bus_addr = a;
    bus.cmd_bus_en   = 1'b1;
    bus.cmd_bus_rd   = 1'b1;
    tick();
    check({name, "_valid"}, {31'd0, bus.rd_valid}, 32'd1);
    check(name, bus.rd_data, exp);
    bus.cmd_bus_en   = 1'b0;
    bus.cmd_bus_rd   = 1'b0;
  endtask

  function automatic logic [31:0] make_entry(input logic [30:0] idx, input logic [31:0] t, input logic p);
`ifdef RECORD_TIMESTAMP_EN
    return {t[30:0], p};
`else
    return {idx, p};
`endif
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp_q[$];
    logic [15:0] pat;
    logic [30:0] idx;
    logic [31:0] t;

    bus.cmd_bus_addr = 16'd0;
    bus.cmd_bus_data = 32'd0;
    bus.cmd_bus_en   = 1'b0;
    bus.cmd_bus_wr   = 1'b0;
    bus.cmd_bus_rd   = 1'b0;

    //             wr    addr      data          v     rd            oe    out
    vecs[0]  = '{1'b0, 16'h0005, 32'd0,        1'b1, 32'd0,        1'b0, 1'b0};
    vecs[1]  = '{1'b0, 16'h0000, 32'd0,        1'b1, 32'd0,        1'b0, 1'b0};
    vecs[2]  = '{1'b1, 16'h0000, 32'd2,        1'b0, 32'd0,        1'b1, 1'b1};
    vecs[3]  = '{1'b0, 16'h0005, 32'd0,        1'b1, 32'd2,        1'b1, 1'b1};
    vecs[4]  = '{1'b1, 16'h0000, 32'd1,        1'b0, 32'd0,        1'b1, 1'b0};
    vecs[5]  = '{1'b0, 16'h0000, 32'd0,        1'b1, 32'd1,        1'b1, 1'b0};
    vecs[6]  = '{1'b1, 16'h0001, 32'h1234,     1'b0, 32'd0,        1'b1, 1'b0};
    vecs[7]  = '{1'b0, 16'h0001, 32'd0,        1'b1, 32'h1234,     1'b1, 1'b0};
    vecs[8]  = '{1'b1, 16'h0002, 32'd7,        1'b0, 32'd0,        1'b1, 1'b0};
    vecs[9]  = '{1'b0, 16'h0002, 32'd0,        1'b1, 32'd7,        1'b1, 1'b0};
    vecs[10] = '{1'b1, 16'h0003, 32'hABCD,     1'b0, 32'd0,        1'b1, 1'b0};
    vecs[11] = '{1'b0, 16'h0003, 32'd0,        1'b1, 32'hABCD,     1'b1, 1'b0};
    vecs[12] = '{1'b0, 16'h0007, 32'd0,        1'b1, 32'd0,        1'b1, 1'b0};
    vecs[13] = '{1'b0, 16'h0004, 32'd0,        1'b1, 32'd0,        1'b1, 1'b0};
    vecs[14] = '{1'b0, 16'h0100, 32'd0,        1'b0, 32'd0,        1'b1, 1'b0};
    vecs[15] = '{1'b1, 16'h0100, 32'd2,        1'b0, 32'd0,        1'b1, 1'b0};
    vecs[16] = '{1'b0, 16'h0000, 32'd0,        1'b1, 32'd1,        1'b1, 1'b0};
    vecs[17] = '{1'b1, 16'h0000, 32'd5,        1'b0, 32'd0,        1'b0, 1'b0};
    vecs[18] = '{1'b1, 16'h0200, 32'd3,        1'b0, 32'd0,        1'b0, 1'b0};
    vecs[19] = '{1'b0, 16'h0001, 32'd0,        1'b1, 32'h1234,     1'b0, 1'b0};

    tick();
    tick();
    check("rst_pin_oe",   {31'd0, pin_oe},       32'd0);
    check("rst_pin_out",  {31'd0, pin_out},      32'd0);
    check("rst_overflow", {31'd0, overflow},     32'd0);
    check("rst_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 20; i++) begin
      bus.cmd_bus_addr = vecs[i].addr;
      bus.cmd_bus_data = vecs[i].data;
      bus.cmd_bus_en   = 1'b1;
      bus.cmd_bus_wr   = vecs[i].wr;
      bus.cmd_bus_rd   = ~vecs[i].wr;
      tick();
      bus.cmd_bus_en = 1'b0;
      bus.cmd_bus_wr = 1'b0;
      bus.cmd_bus_rd = 1'b0;
      check($sformatf("vec%0d_valid", i), {31'd0, bus.rd_valid}, {31'd0, vecs[i].exp_valid});
      check($sformatf("vec%0d_rd", i),    bus.rd_data,           vecs[i].exp_rd);
      check($sformatf("vec%0d_oe", i),    {31'd0, pin_oe},       {31'd0, vecs[i].exp_oe});
      check($sformatf("vec%0d_out", i),   {31'd0, pin_out},      {31'd0, vecs[i].exp_out});
    end

    // rd_valid is a single-cycle pulse
    read_check("pulse_rd", 16'h0002, 32'd7);
    tick();
    check("pulse_valid_low", {31'd0, bus.rd_valid}, 32'd0);
    check("pulse_data_low",  bus.rd_data,           32'd0);

    // simultaneous wr and rd: write wins, no read response
    bus.cmd_bus_addr = 16'h0000;
    bus.cmd_bus_data = 32'd2;
    bus.cmd_bus_en   = 1'b1;
    bus.cmd_bus_wr   = 1'b1;
    bus.cmd_bus_rd   = 1'b1;
    tick();
    bus.cmd_bus_en = 1'b0;
    bus.cmd_bus_wr = 1'b0;
    bus.cmd_bus_rd = 1'b0;
    check("wrrd_no_valid", {31'd0, bus.rd_valid}, 32'd0);
    check("wrrd_pin_oe",   {31'd0, pin_oe},       32'd1);
    check("wrrd_pin_out",  {31'd0, pin_out},      32'd1);

    // square wave 3 high / 2 low
    bus_write(16'h0001, 32'd3);
    bus_write(16'h0002, 32'd2);
    bus_write(16'h0000, 32'd3);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("sq32_oe_%0d", i),  {31'd0, pin_oe},  32'd1);
      check($sformatf("sq32_out_%0d", i), {31'd0, pin_out}, ((i % 5) < 3) ? 32'd1 : 32'd0);
      tick();
    end
    // HIGH_T=0 behaves as one high cycle
    bus_write(16'h0001, 32'd0);
    bus_write(16'h0000, 32'd3);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("sq02_out_%0d", i), {31'd0, pin_out}, ((i % 3) == 0) ? 32'd1 : 32'd0);
      tick();
    end

    // record: DIV=4, 16 cycles -> 4 samples
    pat = 16'b1000_1000_0000_1000;
    idx = 31'd0;
    exp_q.delete();
    bus_write(16'h0003, 32'd4);
    bus_write(16'h0000, 32'd4);
    check("rec_pin_oe", {31'd0, pin_oe}, 32'd0);
    for (int k = 1; k <= 16; k++) begin
      pin_in = pat[k-1];
      t = current_time;
      if ((k % 4) == 0) begin
        exp_q.push_back(make_entry(idx, t, pat[k-1]));
        idx++;
      end
      tick();
    end
    bus_write(16'h0000, 32'd0);
    read_check("rec_status4", 16'h0005, 32'h0000_0200);
    for (int j = 0; j < 4; j++) begin
      read_check($sformatf("rec_sample%0d", j), 16'h0004, exp_q[j]);
    end
    read_check("rec_status0", 16'h0005, 32'd0);

    // overflow: DIV=1 pushes every cycle, 20 samples into 16 entries
    idx = 31'd0;
    exp_q.delete();
    bus_write(16'h0003, 32'd1);
    bus_write(16'h0000, 32'd4);
    for (int k = 1; k <= 20; k++) begin
      pin_in = k[0];
      t = current_time;
      if (k <= 16) begin
        exp_q.push_back(make_entry(idx, t, k[0]));
        idx++;
      end
      tick();
    end
    bus_write(16'h0000, 32'd0);
    check("ovf_flag", {31'd0, overflow}, 32'd1);
    read_check("ovf_status", 16'h0005, 32'h0000_0840);
    read_check("ovf_sample0", 16'h0004, exp_q[0]);
    read_check("ovf_sample1", 16'h0004, exp_q[1]);
    read_check("ovf_status14", 16'h0005, 32'h0000_0740);
    bus_write(16'h0006, 32'd0);
    check("clr_flag", {31'd0, overflow}, 32'd0);
    read_check("clr_status", 16'h0005, 32'd0);

    // asynchronous reset while in SQ_HI
    bus_write(16'h0001, 32'd5);
    bus_write(16'h0000, 32'd3);
    check("pre_rst_oe", {31'd0, pin_oe}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_oe",  {31'd0, pin_oe},  32'd0);
    check("async_rst_out", {31'd0, pin_out}, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    read_check("post_rst_mode",   16'h0000, 32'd0);
    read_check("post_rst_high_t", 16'h0001, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
